// File: rtl/lut_ff_slice_pkg.sv
// Shared definitions for the runtime-configured LUT/FF slice.
//   calc_w / calc_cfg_bits : config bits per cell and per slice
//   INIT_LSB, reg_sel_ofs, ff_init_ofs : field offsets inside one cell's slice
//   state_t : configuration FSM encoding
package lut_ff_slice_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int INIT_LSB = 0;

  // 2**K LUT bits plus REG_SEL and FF_INIT.
  function automatic int calc_w(input int k);
    return (1 << k) + 2;
  endfunction

  function automatic int calc_cfg_bits(input int k, input int n);
    return n * calc_w(k);
  endfunction

  function automatic int reg_sel_ofs(input int k);
    return 1 << k;
  endfunction

  function automatic int ff_init_ofs(input int k);
    return (1 << k) + 1;
  endfunction

endpackage

// File: rtl/lut_ff_slice_if.sv
// Bus bundle between the routing fabric and one logic slice.
//   CFG_EN/CFG_DIN : serial config in, CFG_DOUT : serial config out (daisy chain)
//   CFG_DONE       : slice configured and running
//   CE/I/O         : per-cell clock enables, LUT inputs, cell outputs
// Handshake semantics: there is no backpressure. CFG_EN is a pure qualifier --
// every rising CLK edge with CFG_EN=1 consumes exactly one CFG_DIN bit and
// presents the displaced bit on CFG_DOUT; with CFG_EN=0 the config stream pauses.
interface lut_ff_slice_if #(
  parameter int K = 4,
  parameter int N = 4
);
  logic           CFG_EN;
  logic           CFG_DIN;
  logic           CFG_DOUT;
  logic           CFG_DONE;
  logic [N-1:0]   CE;
  logic [N*K-1:0] I;
  logic [N-1:0]   O;

  modport master (
    output CFG_EN, CFG_DIN, CE, I,
    input  CFG_DOUT, CFG_DONE, O
  );

  modport slave (
    input  CFG_EN, CFG_DIN, CE, I,
    output CFG_DOUT, CFG_DONE, O
  );
endinterface

// File: rtl/lut_ff_slice_cell.sv
// One logic cell: K-input LUT, clock-enabled DFF and output select.
//   clk, rst_n   : clock, synchronous active-low reset
//   cfg          : this cell's W-bit config slice {FF_INIT, REG_SEL, INIT}
//   ff_init_nxt  : FF_INIT bit as it will be after the current edge's shift
//   run          : slice is in RUN
//   init_load    : this edge enters RUN; load FF_INIT instead of the LUT value
//   ce, i        : clock enable and LUT inputs
//   o            : cell output, 0 unless running
module lut_ff_cell
  import lut_ff_slice_pkg::*;
#(
  parameter int  K = 4,
  localparam int W = calc_w(K)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] cfg,
  input  logic         ff_init_nxt,
  input  logic         run,
  input  logic         init_load,
  input  logic         ce,
  input  logic [K-1:0] i,
  output logic         o
);

  localparam int LUT_SIZE = 1 << K;
  localparam int RS_OFS   = reg_sel_ofs(K);
  localparam int FI_OFS   = ff_init_ofs(K);

  logic [LUT_SIZE-1:0] lut_init;
  logic                reg_sel;
  logic [K-1:0]        idx;
  logic                l;
  logic                q;
  logic                unused_ff_init;

  assign lut_init = cfg[INIT_LSB +: LUT_SIZE];
  assign reg_sel  = cfg[RS_OFS];
  // FF_INIT is taken from ff_init_nxt so the load sees the post-shift value.
  assign unused_ff_init = cfg[FI_OFS];

  // Unknown inputs index as 0 in simulation; synthesises to a plain mux select.
  always_comb begin
    idx = '0;
    for (int b = 0; b < K; b++) begin
      idx[b] = (i[b] === 1'b1);
    end
    l = lut_init[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (init_load) begin
      q <= ff_init_nxt;
    end else if (run) begin
      if (ce) begin
        q <= l;
      end
    end else begin
      q <= 1'b0;
    end
  end

  assign o = run ? (reg_sel ? q : l) : 1'b0;

endmodule

// File: rtl/lut_ff_slice.sv
// Runtime-configured slice of N LUT/FF cells loaded through a serial chain.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : config stream, CE, LUT inputs and cell outputs (slave side)
//   DBG_STATE  : configuration FSM state
//   DBG_CNT    : bits accepted in the current load
//   DBG_SR     : config shift register contents
module lut_ff_slice
  import lut_ff_slice_pkg::*;
#(
  parameter int  K        = 4,
  parameter int  N        = 4,
  localparam int W        = calc_w(K),
  localparam int CFG_BITS = calc_cfg_bits(K, N),
  localparam int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic                CLK,
  input  logic                RST_N,
  lut_ff_slice_if.slave       bus,
  output state_t              DBG_STATE,
  output logic [CNT_W-1:0]    DBG_CNT,
  output logic [CFG_BITS-1:0] DBG_SR
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);
  localparam int               FI_OFS   = ff_init_ofs(K);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CFG_BITS-1:0] sr, sr_nxt;
  logic                init_load;
  logic                run;
  logic [N-1:0]        o_cell;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= UNCFG;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // The shift happens in every state; only the bookkeeping depends on state.
  // Any enabled bit while running restarts the load from scratch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_load = 1'b0;
    sr_nxt    = bus.CFG_EN ? {sr[CFG_BITS-2:0], bus.CFG_DIN} : sr;
    case (state)
      UNCFG: begin
        if (bus.CFG_EN) begin
          state_nxt = LOAD;
          cnt_nxt   = CNT_W'(1);
        end
      end
      LOAD: begin
        if (bus.CFG_EN) begin
          if (cnt == CNT_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            init_load = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (bus.CFG_EN) begin
          state_nxt = LOAD;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        state_nxt = UNCFG;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign run = (state == RUN);

  for (genvar n = 0; n < N; n++) begin : g_cell
    lut_ff_cell #(.K(K)) u_cell (
      .clk         (CLK),
      .rst_n       (RST_N),
      .cfg         (sr[n*W +: W]),
      .ff_init_nxt (sr_nxt[n*W + FI_OFS]),
      .run         (run),
      .init_load   (init_load),
      .ce          (bus.CE[n]),
      .i           (bus.I[n*K +: K]),
      .o           (o_cell[n])
    );
  end

  assign bus.O        = o_cell;
  assign bus.CFG_DOUT = sr[CFG_BITS-1];
  assign bus.CFG_DONE = run;

  assign DBG_STATE = state;
  assign DBG_CNT   = cnt;
  assign DBG_SR    = sr;

endmodule

// File: tb/tb_lut_ff_slice.sv
// Bench for lut_ff_slice with K=2, N=2 (W=6, 12 config bits).
// Slice A is the main target; slice B is fed from A's CFG_DOUT for chaining.
module tb_lut_ff_slice;
  import lut_ff_slice_pkg::*;

  localparam logic [11:0] S = 12'b110110_001000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_ff_slice_if #(.K(2), .N(2)) bus_a ();
  lut_ff_slice_if #(.K(2), .N(2)) bus_b ();
  assign bus_b.CFG_DIN = bus_a.CFG_DOUT;

  state_t      st_a, st_b;
  logic [3:0]  cnt_a, cnt_b;
  logic [11:0] sr_a, sr_b;

  lut_ff_slice #(.K(2), .N(2)) u_a (
    .CLK(clk), .RST_N(rst_n), .bus(bus_a),
    .DBG_STATE(st_a), .DBG_CNT(cnt_a), .DBG_SR(sr_a)
  );
  lut_ff_slice #(.K(2), .N(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .bus(bus_b),
    .DBG_STATE(st_b), .DBG_CNT(cnt_b), .DBG_SR(sr_b)
  );

  // ---------------- reference model ----------------
  // Per slice: config image, bits accepted in the current load, running flag, FF values.
  logic [11:0] m_sr [2];
  int          m_bits [2];
  bit          m_run [2];
  logic [1:0]  m_q [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q [$];

  function automatic logic lut_of(input logic [11:0] img, input int n, input logic [1:0] iv);
    logic [3:0] init;
    int idx;
    init = img[n*6 +: 4];
    idx = ((iv[1] === 1'b1) ? 2 : 0) + ((iv[0] === 1'b1) ? 1 : 0);
    return init[idx];
  endfunction

  function automatic logic [1:0] exp_o(input int s, input logic [3:0] iv);
    logic [1:0] r;
    r = 2'b00;
    if (m_run[s]) begin
      for (int n = 0; n < 2; n++) begin
        r[n] = m_sr[s][n*6+4] ? m_q[s][n] : lut_of(m_sr[s], n, iv[n*2 +: 2]);
      end
    end
    return r;
  endfunction

  task automatic model_step(input int s, input logic rst, input logic en, input logic din,
                            input logic [1:0] ce, input logic [3:0] iv);
    logic [11:0] old_sr, new_sr;
    bit last_bit;
    if (!rst) begin
      m_sr[s] = '0; m_bits[s] = 0; m_run[s] = 0; m_q[s] = '0;
      return;
    end
    old_sr   = m_sr[s];
    new_sr   = en ? {old_sr[10:0], din} : old_sr;
    last_bit = en && !m_run[s] && (m_bits[s] == 11);
    for (int n = 0; n < 2; n++) begin
      if (last_bit) m_q[s][n] = new_sr[n*6+5];
      else if (m_run[s]) begin
        if (ce[n]) m_q[s][n] = lut_of(old_sr, n, iv[n*2 +: 2]);
      end else m_q[s][n] = 1'b0;
    end
    if (en) begin
      if (m_run[s]) begin m_run[s] = 0; m_bits[s] = 1; end
      else if (last_bit) begin m_run[s] = 1; m_bits[s] = 0; end
      else m_bits[s] = m_bits[s] + 1;
    end
    m_sr[s] = new_sr;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("a_done", 32'(bus_a.CFG_DONE), 32'(m_run[0]));
    check_val("a_dout", 32'(bus_a.CFG_DOUT), 32'(m_sr[0][11]));
    check_val("a_o",    32'(bus_a.O),        32'(exp_o(0, bus_a.I)));
    check_val("a_sr",   32'(sr_a),           32'(m_sr[0]));
    check_val("a_cnt",  32'(cnt_a),          32'(m_bits[0]));
    check_val("b_done", 32'(bus_b.CFG_DONE), 32'(m_run[1]));
    check_val("b_o",    32'(bus_b.O),        32'(exp_o(1, bus_b.I)));
    check_val("b_sr",   32'(sr_b),           32'(m_sr[1]));
    check_val("b_cnt",  32'(cnt_b),          32'(m_bits[1]));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; the model advances on the rising edge.
  task automatic cycle();
    logic a_dout;
    @(posedge clk);
    a_dout = m_sr[0][11];
    model_step(0, rst_n, bus_a.CFG_EN, bus_a.CFG_DIN, bus_a.CE, bus_a.I);
    model_step(1, rst_n, bus_b.CFG_EN, a_dout, bus_b.CE, bus_b.I);
    @(negedge clk);
    check_all();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic shift_bit(input logic b);
    bus_a.CFG_EN  = 1'b1;
    bus_a.CFG_DIN = b;
    cycle();
    bus_a.CFG_EN  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] r_cfg;
    logic [23:0] chain;
    rst_n = 1'b0;
    bus_a.CFG_EN = 1'b0; bus_a.CFG_DIN = 1'b0; bus_a.CE = '0; bus_a.I = '0;
    bus_b.CFG_EN = 1'b0; bus_b.CE = '0; bus_b.I = '0;
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = '0; m_bits[k] = 0; m_run[k] = 0; m_q[k] = '0;
    end
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    check_val("rst_done", 32'(bus_a.CFG_DONE), 32'd0);
    check_val("rst_o",    32'(bus_a.O),        32'd0);
    check_val("rst_dout", 32'(bus_a.CFG_DOUT), 32'd0);

    // Plain load of S, MSB first.
    for (int j = 11; j >= 0; j--) begin
      check_val("load_done_low", 32'(bus_a.CFG_DONE), 32'd0);
      check_val("load_o_low",    32'(bus_a.O),        32'd0);
      shift_bit(S[j]);
    end
    check_val("load_done", 32'(bus_a.CFG_DONE), 32'd1);
    check_val("entry_o",   32'(bus_a.O),        32'b10);
    bus_a.I = 4'b1111; settle();
    check_val("and_11", 32'(bus_a.O), 32'b11);
    bus_a.I = 4'b1101; settle();
    check_val("and_01", 32'(bus_a.O), 32'b10);

    // Registered XOR cell under CE control.
    bus_a.CE = 2'b10; bus_a.I = 4'b0100; cycle();
    check_val("xor_q_01", 32'(bus_a.O[1]), 32'd1);
    bus_a.I = 4'b1100; cycle();
    check_val("xor_q_11", 32'(bus_a.O[1]), 32'd0);
    bus_a.CE = 2'b00;
    for (int j = 0; j < 3; j++) begin
      bus_a.I = (j % 2 == 0) ? 4'b0100 : 4'b1000;
      cycle();
      check_val("ce_hold", 32'(bus_a.O[1]), 32'd0);
    end

    // Load with a 3-cycle pause after bit 5.
    do_reset();
    for (int j = 11; j >= 7; j--) shift_bit(S[j]);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check_val("gap_cnt", 32'(cnt_a), 32'd5);
    end
    for (int j = 6; j >= 0; j--) begin
      check_val("gap_done_low", 32'(bus_a.CFG_DONE), 32'd0);
      shift_bit(S[j]);
    end
    check_val("gap_done", 32'(bus_a.CFG_DONE), 32'd1);
    check_val("gap_sr",   32'(sr_a),           32'(S));

    // Reset in the middle of a load.
    for (int j = 11; j >= 5; j--) shift_bit(S[j]);
    rst_n = 1'b0; bus_a.CFG_EN = 1'b1; bus_a.CE = 2'b11; cycle();
    rst_n = 1'b1; bus_a.CFG_EN = 1'b0; bus_a.CE = 2'b00;
    check_val("midrst_sr",    32'(sr_a), 32'd0);
    check_val("midrst_state", 32'(st_a), 32'(UNCFG));
    check_val("midrst_o",     32'(bus_a.O), 32'd0);
    for (int j = 11; j >= 0; j--) shift_bit(S[j]);
    check_val("reload_done", 32'(bus_a.CFG_DONE), 32'd1);
    check_val("reload_sr",   32'(sr_a),           32'(S));

    // Reconfigure while running; old image streams out of CFG_DOUT.
    r_cfg = 12'($urandom_range(0, 4095));
    for (int j = 11; j >= 0; j--) exp_q.push_back(12'(S[j]));
    bus_a.I = 4'b1111; bus_a.CE = 2'b11;
    for (int j = 11; j >= 0; j--) begin
      check_val("dout_stream", 32'(bus_a.CFG_DOUT), 32'(exp_q.pop_front()));
      shift_bit(r_cfg[j]);
      if (j == 11) begin
        check_val("reconf_done", 32'(bus_a.CFG_DONE), 32'd0);
        check_val("reconf_o",    32'(bus_a.O),        32'd0);
      end
    end
    check_val("reconf_sr",   32'(sr_a),           32'(r_cfg));
    check_val("reconf_fin",  32'(bus_a.CFG_DONE), 32'd1);
    bus_a.I = 4'bx1x1; settle();
    bus_a.I = 4'b0000;

    // Random traffic: LUT inputs, clock enables, occasional reloads and resets.
    for (int c = 0; c < 400; c++) begin
      bus_a.I  = 4'($urandom_range(0, 15));
      bus_a.CE = 2'($urandom_range(0, 3));
      bus_b.I  = 4'($urandom_range(0, 15));
      bus_b.CE = 2'($urandom_range(0, 3));
      if (m_run[0]) bus_a.CFG_EN = ($urandom_range(0, 29) == 0);
      else          bus_a.CFG_EN = ($urandom_range(0, 3) != 0);
      bus_a.CFG_DIN = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 149) != 0);
      settle();
      cycle();
    end
    rst_n = 1'b1; bus_a.CFG_EN = 1'b0;

    // Daisy chain: 24 bits through A into B.
    do_reset();
    chain = 24'($urandom_range(0, 32'hFF_FFFF));
    bus_b.CFG_EN = 1'b1;
    for (int j = 23; j >= 0; j--) begin
      if (j == 0) begin
        check_val("chain_a_low", 32'(bus_a.CFG_DONE), 32'd0);
        check_val("chain_b_low", 32'(bus_b.CFG_DONE), 32'd0);
      end
      shift_bit(chain[j]);
    end
    bus_b.CFG_EN = 1'b0;
    check_val("chain_a_done", 32'(bus_a.CFG_DONE), 32'd1);
    check_val("chain_b_done", 32'(bus_b.CFG_DONE), 32'd1);
    check_val("chain_a_sr",   32'(sr_a), 32'(chain[11:0]));
    check_val("chain_b_sr",   32'(sr_b), 32'(chain[23:12]));

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
